// File: rtl/bfly_pair_buf.sv
// Butterfly operand pairing buffer: the first DEPTH vectors of each 2*DEPTH
// block are stored. Each of the next DEPTH vectors is paired with the stored
// vector DEPTH positions earlier, and the pair is emitted as (x[k], x[k+DEPTH])
// for the add/sub stage.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   clr                   synchronous block restart (wins over din_valid)
//   din_valid             input vector valid
//   din_re/din_im         input vector, DATA_WIDTH signed lanes of WIDTH bits
//   dout_valid            one-cycle strobe per butterfly pair
//   dout_a_re/dout_a_im   upper operand x[k]
//   dout_b_re/dout_b_im   lower operand x[k+DEPTH]
//   pair_idx              k of the current pair
//   blk_last              marks the final pair of a block (k = DEPTH-1)
module bfly_pair_buf #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     din_valid,
  input  logic signed [WIDTH-1:0]  din_re    [0:DATA_WIDTH-1],
  input  logic signed [WIDTH-1:0]  din_im    [0:DATA_WIDTH-1],
  output logic                     dout_valid,
  output logic signed [WIDTH-1:0]  dout_a_re [0:DATA_WIDTH-1],
  output logic signed [WIDTH-1:0]  dout_a_im [0:DATA_WIDTH-1],
  output logic signed [WIDTH-1:0]  dout_b_re [0:DATA_WIDTH-1],
  output logic signed [WIDTH-1:0]  dout_b_im [0:DATA_WIDTH-1],
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] pair_idx,
  output logic                     blk_last
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(2 * DEPTH);
  localparam logic [CNT_W-1:0] SLOT_MASK = CNT_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  // Position within the current block; MSB set means pair phase.
  logic [CNT_W-1:0] cnt;

  logic             accept_c;
  logic             pair_c;
  logic [IDX_W-1:0] slot_c;

  // Half-block storage; contents are always written before being read.
  logic signed [WIDTH-1:0] mem_re [0:DEPTH-1][0:DATA_WIDTH-1];
  logic signed [WIDTH-1:0] mem_im [0:DEPTH-1][0:DATA_WIDTH-1];

  assign accept_c = din_valid & ~clr;
  assign pair_c   = cnt[CNT_W-1];
  // Low bits of cnt give the entry for both phases (DEPTH is a power of two).
  assign slot_c   = IDX_W'(cnt & SLOT_MASK);

  // Fill-phase write. The same entry is read in pair phase before the next
  // block's fill reaches it, so back-to-back blocks need no gap.
  always_ff @(posedge clk) begin
    if (accept_c && !pair_c) begin
      for (int unsigned l = 0; l < DATA_WIDTH; l++) begin
        mem_re[slot_c][l] <= din_re[l];
        mem_im[slot_c][l] <= din_im[l];
      end
    end
  end

  // Block counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (din_valid) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Strobes: one cycle per pair-phase vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      blk_last   <= 1'b0;
    end else begin
      dout_valid <= accept_c & pair_c;
      blk_last   <= accept_c & pair_c & (slot_c == LAST_IDX);
    end
  end

  // Pair registers; they hold their last value between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_idx <= '0;
      for (int unsigned l = 0; l < DATA_WIDTH; l++) begin
        dout_a_re[l] <= '0;
        dout_a_im[l] <= '0;
        dout_b_re[l] <= '0;
        dout_b_im[l] <= '0;
      end
    end else if (accept_c && pair_c) begin
      pair_idx <= slot_c;
      for (int unsigned l = 0; l < DATA_WIDTH; l++) begin
        dout_a_re[l] <= mem_re[slot_c][l];
        dout_a_im[l] <= mem_im[slot_c][l];
        dout_b_re[l] <= din_re[l];
        dout_b_im[l] <= din_im[l];
      end
    end
  end

endmodule

// File: tb/tb_bfly_pair_buf.sv
// Directed bench for bfly_pair_buf: a DEPTH=4 instance and a DEPTH=1 instance,
// both WIDTH=10, DATA_WIDTH=16. Vectors are identified by a small integer
// "base"; lane contents are derived from it so that lanes, re and im all differ.
module tb_bfly_pair_buf;

  localparam int W = 10;
  localparam int N = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic clr;
  logic v0, v1;
  logic signed [W-1:0] d0_re [0:N-1];
  logic signed [W-1:0] d0_im [0:N-1];
  logic signed [W-1:0] d1_re [0:N-1];
  logic signed [W-1:0] d1_im [0:N-1];

  logic                dv0, last0, dv1, last1;
  logic [1:0]          idx0;
  logic [0:0]          idx1;
  logic signed [W-1:0] a0_re [0:N-1];
  logic signed [W-1:0] a0_im [0:N-1];
  logic signed [W-1:0] b0_re [0:N-1];
  logic signed [W-1:0] b0_im [0:N-1];
  logic signed [W-1:0] a1_re [0:N-1];
  logic signed [W-1:0] a1_im [0:N-1];
  logic signed [W-1:0] b1_re [0:N-1];
  logic signed [W-1:0] b1_im [0:N-1];

  int total = 0;
  int bad   = 0;

  logic [319:0] hold_a [2];
  logic [319:0] hold_b [2];
  int           hold_idx [2];

  bfly_pair_buf #(.WIDTH(W), .DATA_WIDTH(N), .DEPTH(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .din_valid(v0),
    .din_re(d0_re), .din_im(d0_im),
    .dout_valid(dv0),
    .dout_a_re(a0_re), .dout_a_im(a0_im),
    .dout_b_re(b0_re), .dout_b_im(b0_im),
    .pair_idx(idx0), .blk_last(last0)
  );

  bfly_pair_buf #(.WIDTH(W), .DATA_WIDTH(N), .DEPTH(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .din_valid(v1),
    .din_re(d1_re), .din_im(d1_im),
    .dout_valid(dv1),
    .dout_a_re(a1_re), .dout_a_im(a1_im),
    .dout_b_re(b1_re), .dout_b_im(b1_im),
    .pair_idx(idx1), .blk_last(last1)
  );

  // base 1000/1001: full-scale alternating patterns, otherwise a lane ramp.
  function automatic logic signed [W-1:0] lane_re(input int base, input int l);
    if (base == 1000) return (l % 2 == 0) ? W'(-512) : W'(511);
    if (base == 1001) return (l % 2 == 0) ? W'(511) : W'(-512);
    return W'(base + 16 * l);
  endfunction

  function automatic logic signed [W-1:0] lane_im(input int base, input int l);
    if (base == 1000) return (l % 2 == 0) ? W'(511) : W'(-512);
    if (base == 1001) return (l % 2 == 0) ? W'(-512) : W'(511);
    return W'(-base - 7 * l);
  endfunction

  function automatic logic [319:0] exp_vec(input int base);
    logic [319:0] r;
    r = '0;
    for (int l = 0; l < N; l++) begin
      r[l*W +: W]       = lane_re(base, l);
      r[160 + l*W +: W] = lane_im(base, l);
    end
    return r;
  endfunction

  function automatic logic [319:0] pack_v(input logic signed [W-1:0] re [0:N-1],
                                          input logic signed [W-1:0] im [0:N-1]);
    logic [319:0] r;
    r = '0;
    for (int l = 0; l < N; l++) begin
      r[l*W +: W]       = re[l];
      r[160 + l*W +: W] = im[l];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive a vector (or idle) into the selected instance, then
  // check every output of that instance just after the edge.
  task automatic step(input int sel, input bit v, input bit c, input int base,
                      input bit ev, input int ea, input int eb, input int eidx,
                      input bit elast, input string tag);
    for (int l = 0; l < N; l++) begin
      if (sel == 0) begin
        d0_re[l] = lane_re(base, l);
        d0_im[l] = lane_im(base, l);
      end else begin
        d1_re[l] = lane_re(base, l);
        d1_im[l] = lane_im(base, l);
      end
    end
    if (sel == 0) v0 = v; else v1 = v;
    clr = c;
    @(posedge clk);
    #1;
    v0  = 1'b0;
    v1  = 1'b0;
    clr = 1'b0;
    if (ev) begin
      hold_a[sel]   = exp_vec(ea);
      hold_b[sel]   = exp_vec(eb);
      hold_idx[sel] = eidx;
    end
    if (sel == 0) begin
      check({tag, ".valid"}, 320'(dv0), 320'(ev));
      check({tag, ".last"},  320'(last0), 320'(elast));
      check({tag, ".idx"},   320'(idx0), 320'(hold_idx[0]));
      check({tag, ".a"},     pack_v(a0_re, a0_im), hold_a[0]);
      check({tag, ".b"},     pack_v(b0_re, b0_im), hold_b[0]);
    end else begin
      check({tag, ".valid"}, 320'(dv1), 320'(ev));
      check({tag, ".last"},  320'(last1), 320'(elast));
      check({tag, ".idx"},   320'(idx1), 320'(hold_idx[1]));
      check({tag, ".a"},     pack_v(a1_re, a1_im), hold_a[1]);
      check({tag, ".b"},     pack_v(b1_re, b1_im), hold_b[1]);
    end
  endtask

  task automatic idle(input int sel, input string tag);
    step(sel, 1'b0, 1'b0, 0, 1'b0, 0, 0, 0, 1'b0, tag);
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    v0    = 1'b0;
    v1    = 1'b0;
    for (int l = 0; l < N; l++) begin
      d0_re[l] = '0; d0_im[l] = '0; d1_re[l] = '0; d1_im[l] = '0;
    end
    for (int s = 0; s < 2; s++) begin
      hold_a[s] = '0; hold_b[s] = '0; hold_idx[s] = 0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 320'(dv0), 320'(0));
    check("rst.last",  320'(last0), 320'(0));
    check("rst.idx",   320'(idx0), 320'(0));
    check("rst.a",     pack_v(a0_re, a0_im), '0);
    check("rst.b",     pack_v(b0_re, b0_im), '0);
    check("rst.valid1", 320'(dv1), 320'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back block 1..8
    for (int b = 1; b <= 4; b++) step(0, 1, 0, b, 0, 0, 0, 0, 0, "b2b.fill");
    for (int k = 0; k < 4; k++) step(0, 1, 0, 5 + k, 1, 1 + k, 5 + k, k, k == 3, "b2b.pair");
    idle(0, "b2b.idle");

    // Same pattern with din_valid toggling
    for (int b = 11; b <= 14; b++) begin
      step(0, 1, 0, b, 0, 0, 0, 0, 0, "gap.fill");
      idle(0, "gap.fidle");
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0, 15 + k, 1, 11 + k, 15 + k, k, k == 3, "gap.pair");
      idle(0, "gap.pidle");
    end

    // clr with the 6th vector, then a clean block
    for (int b = 21; b <= 24; b++) step(0, 1, 0, b, 0, 0, 0, 0, 0, "clr.fill");
    step(0, 1, 0, 25, 1, 21, 25, 0, 0, "clr.pair0");
    step(0, 1, 1, 26, 0, 0, 0, 0, 0, "clr.drop");
    for (int b = 31; b <= 34; b++) step(0, 1, 0, b, 0, 0, 0, 0, 0, "clr.refill");
    for (int k = 0; k < 4; k++) step(0, 1, 0, 35 + k, 1, 31 + k, 35 + k, k, k == 3, "clr.repair");

    // Async reset mid-block
    for (int b = 41; b <= 44; b++) step(0, 1, 0, b, 0, 0, 0, 0, 0, "ar.fill");
    step(0, 1, 0, 45, 1, 41, 45, 0, 0, "ar.pair0");
    step(0, 1, 0, 46, 1, 42, 46, 1, 0, "ar.pair1");
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.valid", 320'(dv0), 320'(0));
    check("ar.last",  320'(last0), 320'(0));
    check("ar.idx",   320'(idx0), 320'(0));
    check("ar.a",     pack_v(a0_re, a0_im), '0);
    check("ar.b",     pack_v(b0_re, b0_im), '0);
    hold_a[0] = '0; hold_b[0] = '0; hold_idx[0] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int b = 51; b <= 54; b++) step(0, 1, 0, b, 0, 0, 0, 0, 0, "ar.refill");
    for (int k = 0; k < 4; k++) step(0, 1, 0, 55 + k, 1, 51 + k, 55 + k, k, k == 3, "ar.repair");

    // Full-scale lanes
    step(0, 1, 0, 1000, 0, 0, 0, 0, 0, "fs.fill");
    step(0, 1, 0, 1001, 0, 0, 0, 0, 0, "fs.fill");
    step(0, 1, 0, 1000, 0, 0, 0, 0, 0, "fs.fill");
    step(0, 1, 0, 1001, 0, 0, 0, 0, 0, "fs.fill");
    step(0, 1, 0, 1001, 1, 1000, 1001, 0, 0, "fs.pair0");
    step(0, 1, 0, 1000, 1, 1001, 1000, 1, 0, "fs.pair1");
    step(0, 1, 0, 1001, 1, 1000, 1001, 2, 0, "fs.pair2");
    step(0, 1, 0, 1000, 1, 1001, 1000, 3, 1, "fs.pair3");

    // DEPTH=1: alternate fill/pair
    step(1, 1, 0, 3,  0, 0, 0,  0, 0, "d1.fill0");
    step(1, 1, 0, -3, 1, 3, -3, 0, 1, "d1.pair0");
    idle(1, "d1.idle");
    step(1, 1, 0, 7,  0, 0, 0,  0, 0, "d1.fill1");
    step(1, 1, 0, -7, 1, 7, -7, 0, 1, "d1.pair1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bfly_pair_buf.md
BFLY_PAIR_BUF -- requirements
Module: bfly_pair_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 10, signed bit width of each real/imag lane sample.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, number of lanes per vector.
REQ-003 SHALL have parameter DEPTH, default 4, vectors per half-block; power of two, >= 1.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port clr  input  1  synchronous block restart.
REQ-007 SHALL have port din_valid  input  1  din vector valid this cycle.
REQ-008 SHALL have ports din_re, din_im  input  signed [WIDTH-1:0] x [0:DATA_WIDTH-1]  input vector.
REQ-009 SHALL have port dout_valid  output  1  butterfly pair valid.
REQ-010 SHALL have ports dout_a_re, dout_a_im  output  signed [WIDTH-1:0] x [0:DATA_WIDTH-1]  upper operand x[k].
REQ-011 SHALL have ports dout_b_re, dout_b_im  output  signed [WIDTH-1:0] x [0:DATA_WIDTH-1]  lower operand x[k+DEPTH].
REQ-012 SHALL have port pair_idx  output  max(1,$clog2(DEPTH))  k of the current pair.
REQ-013 SHALL have port blk_last  output  1  high with the final pair (k = DEPTH-1) of a block.

Function
REQ-014 SHALL hold a counter cnt, range 0..2*DEPTH-1, advanced by 1 on each accepted vector (din_valid=1, clr=0), wrapping from 2*DEPTH-1 to 0.
REQ-015 SHALL, in fill phase (cnt < DEPTH), write din into buffer entry cnt and leave dout_valid=0 the next cycle.
REQ-016 SHALL, in pair phase (cnt >= DEPTH), register a = buffer[cnt-DEPTH] and b = din (lane for lane, re and im), with pair_idx = cnt-DEPTH, and assert dout_valid for exactly one cycle.
REQ-017 SHALL have a latency of 1 cycle from a pair-phase din_valid to dout_valid.
REQ-018 SHALL assert blk_last together with dout_valid when pair_idx = DEPTH-1, and hold it low otherwise.
REQ-019 SHALL leave cnt, buffer and outputs unchanged while din_valid=0; gaps of any length are legal.
REQ-020 SHALL, when clr=1, set cnt to 0 and dout_valid/blk_last to 0 next cycle, dropping any din that cycle (clr wins over din_valid).
REQ-021 SHALL hold dout_a/dout_b/pair_idx at their last values while dout_valid=0.
REQ-022 SHALL pass samples bit-exact: no scaling, rounding or sign change.
REQ-023 SHALL behave with DEPTH=1 as alternate fill/pair, with pair_idx always 0 and blk_last = dout_valid.
REQ-024 SHALL accept a back-to-back next block without a gap; buffer entry k is overwritten only after it has been read in pair phase.
REQ-025 SHALL require no backpressure; the consumer (add/sub stage, then the add/sub select mux) accepts every dout_valid.

Reset
REQ-026 SHALL, on rst_n=0 at any time (asynchronous), set cnt=0, dout_valid=0, blk_last=0, pair_idx=0, and all dout lanes to 0.
REQ-027 SHALL leave buffer contents unreset; they are never output before being rewritten.
REQ-028 SHALL, on reset mid-block, discard the partial block; the first vector after release is fill entry 0.

Verification
REQ-029 SHALL pass: DEPTH=4, 8 consecutive vectors with lane0 re = 1..8 -> dout_valid on cycles 5..8 with (a,b) = (1,5),(2,6),(3,7),(4,8), pair_idx 0..3, blk_last only with (4,8).
REQ-030 SHALL pass: same stream with din_valid toggling 1/0 -> identical pairs, each dout_valid exactly 1 cycle after its pair-phase input.
REQ-031 SHALL pass: clr asserted together with the 6th vector -> no output for it; the next 8 vectors form a clean block starting at pair_idx 0.
REQ-032 SHALL pass: rst_n low asynchronously after 6 vectors -> outputs 0 immediately; after release, 8 new vectors yield 4 correct pairs.
REQ-033 SHALL pass: lane values -512 and 511 (WIDTH=10) on all 16 lanes, re and im -> output bit-exact, with no lane swap.
REQ-034 SHALL pass: DEPTH=1, vectors 3,-3,7,-7 -> pairs (3,-3),(7,-7), each with blk_last=1.
